// File: rtl/alu_control_unit.sv
// alu_control_unit: four-phase (IDLE/DECODE/EXEC/WB) sequencer that feeds a
// combinational 32-bit ALU from an internal register file and tracks C/Z/N flags.
module alu_control_unit #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    output logic [5:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_cout,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic              done,
    output logic              illegal,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    typedef enum logic [5:0] {
        OP_LDI = 6'b000001,
        OP_ADD = 6'b010000,
        OP_SUB = 6'b010001,
        OP_EQ  = 6'b100000,
        OP_NE  = 6'b100001,
        OP_LE  = 6'b100010,
        OP_GT  = 6'b100011,
        OP_LLS = 6'b110000,
        OP_LRS = 6'b110001,
        OP_ARS = 6'b110010
    } opcode_t;

    state_t              r_state;
    logic [5:0]          r_opcode;
    logic [AW-1:0]       r_rd;
    logic [AW-1:0]       r_rs1;
    logic [AW-1:0]       r_rs2;
    logic [15:0]         r_imm;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [5:0]          r_alu_op;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [DATA_W-1:0]   r_res;
    logic                r_cout;
    logic                r_alu_z;
    logic                r_alu_n;
    logic                r_done;
    logic                r_illegal;
    logic                r_flag_c;
    logic                r_flag_z;
    logic                r_flag_n;

    logic                w_is_alu;
    logic                w_is_ldi;
    logic                w_is_cmp;
    logic                w_is_arith;
    logic                w_unused;

    always_comb begin
        w_is_alu   = 1'b0;
        w_is_ldi   = 1'b0;
        w_is_cmp   = 1'b0;
        w_is_arith = 1'b0;
        case (r_opcode)
            OP_ADD, OP_SUB: begin
                w_is_alu   = 1'b1;
                w_is_arith = 1'b1;
            end
            OP_EQ, OP_NE, OP_LE, OP_GT: begin
                w_is_alu = 1'b1;
                w_is_cmp = 1'b1;
            end
            OP_LLS, OP_LRS, OP_ARS: w_is_alu = 1'b1;
            OP_LDI:                 w_is_ldi = 1'b1;
            default: ;
        endcase
    end

    // Upper register-address bits are ignored when NUM_REGS < 32.
    assign w_unused = ^{in_instr[25:21], in_instr[20:16]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_opcode  <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_alu_op  <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_res     <= '0;
            r_cout    <= 1'b0;
            r_alu_z   <= 1'b0;
            r_alu_n   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_flag_c  <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_n  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_opcode <= in_instr[31:26];
                        r_rd     <= in_instr[21 +: AW];
                        r_rs1    <= in_instr[16 +: AW];
                        r_rs2    <= in_instr[11 +: AW];
                        r_imm    <= in_instr[15:0];
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Operands are captured here, so rd aliasing rs1/rs2 sees the old value.
                    if (w_is_alu) begin
                        r_alu_op <= r_opcode;
                        r_alu_a  <= r_regs[r_rs1];
                        r_alu_b  <= r_regs[r_rs2];
                    end
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_res     <= alu_res;
                    r_cout    <= alu_cout;
                    r_alu_z   <= alu_z;
                    r_alu_n   <= alu_n;
                    r_alu_op  <= '0;
                    r_alu_a   <= '0;
                    r_alu_b   <= '0;
                    r_done    <= w_is_alu | w_is_ldi;
                    r_illegal <= ~(w_is_alu | w_is_ldi);
                    r_state   <= S_WB;
                end
                S_WB: begin
                    if (w_is_alu) begin
                        r_regs[r_rd] <= w_is_cmp ? {{(DATA_W-1){1'b0}}, r_res[0]} : r_res;
                        r_flag_z     <= r_alu_z;
                        r_flag_n     <= r_alu_n;
                        if (w_is_arith) begin
                            r_flag_c <= r_cout;
                        end
                    end else if (w_is_ldi) begin
                        r_regs[r_rd] <= {{(DATA_W-16){1'b0}}, r_imm};
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign alu_op   = r_alu_op;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_cin  = r_flag_c;
    assign done     = r_done;
    assign illegal  = r_illegal;
    assign flag_c   = r_flag_c;
    assign flag_z   = r_flag_z;
    assign flag_n   = r_flag_n;
    assign dbg_data = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: directed and random instructions against a
// register/flag reference model, with a behavioural ALU attached to the DUT.
module tb_alu_control_unit;

    localparam int NR = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic [5:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_cin;
    logic [31:0] alu_res;
    logic        alu_cout;
    logic        alu_z;
    logic        alu_n;
    logic        done;
    logic        illegal;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;
    logic [2:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_regs [NR];
    bit          m_c, m_z, m_n;

    always #5 clk = ~clk;

    alu_control_unit #(.NUM_REGS(NR), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_res(alu_res), .alu_cout(alu_cout), .alu_z(alu_z),
        .alu_n(alu_n), .done(done), .illegal(illegal), .flag_c(flag_c),
        .flag_z(flag_z), .flag_n(flag_n), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: bit 32 of the result is carry-out (ADD) or borrow-out (SUB).
    function automatic logic [32:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        case (op)
            6'h10:   return {1'b0, a} + {1'b0, b} + 33'(cin);
            6'h11:   return {1'b0, a} - {1'b0, b} - 33'(cin);
            6'h20:   return {32'b0, a == b};
            6'h21:   return {32'b0, a != b};
            6'h22:   return {32'b0, a <= b};
            6'h23:   return {32'b0, a > b};
            6'h30:   return {1'b0, a << b[4:0]};
            6'h31:   return {1'b0, a >> b[4:0]};
            6'h32:   return {1'b0, 32'($signed(a) >>> b[4:0])};
            default: return '0;
        endcase
    endfunction

    logic [32:0] alu_w;
    always_comb begin
        alu_w    = ref_alu(alu_op, alu_a, alu_b, alu_cin);
        alu_res  = alu_w[31:0];
        alu_cout = alu_w[32];
        alu_z    = (alu_w[31:0] == 32'h0);
        alu_n    = alu_w[31];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input int unsigned idx, input logic [31:0] exp);
        dbg_addr = 3'(idx);
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic run_instr(input logic [5:0] op, input int unsigned rd,
                             input int unsigned rs1, input int unsigned rs2,
                             input logic [15:0] imm);
        logic [31:0] instr, a, b, wval;
        logic [32:0] r;
        bit          is_alu, is_ldi, is_arith;
        int unsigned waited;
        is_ldi   = (op == 6'h01);
        is_arith = (op == 6'h10) || (op == 6'h11);
        is_alu   = is_arith || (op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h30, 6'h31, 6'h32});
        instr    = {op, 5'(rd), 5'(rs1), 16'h0};
        if (is_ldi) instr[15:0] = imm;
        else        instr[15:0] = {5'(rs2), 11'($urandom)};
        a = m_regs[rs1 % NR];
        b = m_regs[rs2 % NR];
        r = ref_alu(op, a, b, m_c);

        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk);
        @(negedge clk);                       // DECODE
        in_instr = $urandom;                  // valid held while busy must be ignored
        chk("decode_ready", {31'b0, in_ready}, 32'd0);
        chk("decode_op",    {26'b0, alu_op},   32'd0);
        @(negedge clk);                       // EXEC
        chk("exec_op",  {26'b0, alu_op}, is_alu ? {26'b0, op} : 32'd0);
        chk("exec_a",   alu_a,           is_alu ? a : 32'd0);
        chk("exec_b",   alu_b,           is_alu ? b : 32'd0);
        chk("exec_cin", {31'b0, alu_cin}, {31'b0, m_c});
        @(negedge clk);                       // WB
        in_valid = 1'b0;
        chk("wb_done",    {31'b0, done},    {31'b0, is_alu || is_ldi});
        chk("wb_illegal", {31'b0, illegal}, {31'b0, !(is_alu || is_ldi)});
        chk("wb_op",      {26'b0, alu_op},  32'd0);
        @(negedge clk);                       // back in IDLE
        if (is_alu) begin
            wval = r[31:0];
            m_regs[rd % NR] = wval;
            m_z = (wval == 32'h0);
            m_n = wval[31];
            if (is_arith) m_c = r[32];
        end else if (is_ldi) begin
            m_regs[rd % NR] = {16'h0, imm};
        end
        chk("idle_ready", {31'b0, in_ready}, 32'd1);
        chk("idle_done",  {31'b0, done},     32'd0);
        chk("flags", {29'b0, flag_c, flag_z, flag_n}, {29'b0, m_c, m_z, m_n});
        check_reg("wb_reg", rd % NR, m_regs[rd % NR]);
    endtask

    logic [5:0] ops [11];

    initial begin
        ops = '{6'h10, 6'h11, 6'h20, 6'h21, 6'h22, 6'h23, 6'h30, 6'h31, 6'h32, 6'h01, 6'h01};
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_c = 0; m_z = 0; m_n = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready",   {31'b0, in_ready}, 32'd1);
        chk("rst_done",    {30'b0, done, illegal}, 32'd0);
        chk("rst_op",      {26'b0, alu_op}, 32'd0);
        chk("rst_ab",      alu_a | alu_b, 32'd0);
        chk("rst_flags",   {29'b0, flag_c, flag_z, flag_n}, 32'd0);
        for (int i = 0; i < NR; i++) check_reg("rst_reg", i, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed sequence
        run_instr(6'h01, 1, 0, 0, 16'h0005);
        run_instr(6'h01, 2, 0, 0, 16'h0003);
        run_instr(6'h10, 3, 1, 2, 16'h0);
        check_reg("add_r3", 3, 32'h0000_0008);
        chk("add_flags", {29'b0, flag_c, flag_z, flag_n}, 32'd0);
        run_instr(6'h01, 1, 0, 0, 16'h0000);
        run_instr(6'h11, 4, 1, 2, 16'h0);
        check_reg("sub_r4", 4, 32'hFFFF_FFFD);
        chk("sub_flags", {29'b0, flag_c, flag_z, flag_n}, 32'd5);
        run_instr(6'h10, 0, 2, 2, 16'h0);     // EXEC must present cin=1
        run_instr(6'h20, 5, 1, 1, 16'h0);
        check_reg("eq_r5", 5, 32'h0000_0001);
        chk("eq_z", {31'b0, flag_z}, 32'd0);
        run_instr(6'h01, 1, 0, 0, 16'h0005);
        run_instr(6'h23, 6, 2, 1, 16'h0);
        check_reg("gt_r6", 6, 32'h0000_0000);
        chk("gt_z", {31'b0, flag_z}, 32'd1);
        run_instr(6'h01, 1, 0, 0, 16'h8000);
        run_instr(6'h01, 2, 0, 0, 16'd16);
        run_instr(6'h30, 7, 1, 2, 16'h0);
        check_reg("lls_r7", 7, 32'h8000_0000);
        chk("lls_n", {31'b0, flag_n}, 32'd1);
        run_instr(6'h3F, 7, 1, 2, 16'h0);     // undefined opcode
        check_reg("illegal_r7", 7, 32'h8000_0000);
        run_instr(6'h11, 3, 3, 3, 16'h0);     // rd aliases both sources

        // Random instructions, including full 5-bit register fields
        for (int k = 0; k < 40; k++) begin
            int unsigned sel;
            logic [5:0] op;
            sel = $urandom_range(0, 11);
            if (sel < 11) op = ops[sel];
            else          op = 6'($urandom);
            run_instr(op, $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), 16'($urandom));
        end

        // Reset dropped during EXEC of an ADD
        run_instr(6'h01, 3, 0, 0, 16'h1234);
        in_valid = 1'b1;
        in_instr = {6'h10, 5'd3, 5'd3, 5'd3, 11'h0};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);                       // EXEC
        rst_n = 1'b0;
        #1;
        chk("arst_op",    {26'b0, alu_op}, 32'd0);
        chk("arst_ab",    alu_a | alu_b, 32'd0);
        chk("arst_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_done",  {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_c = 0; m_z = 0; m_n = 0;
        @(negedge clk);
        chk("post_done",  {31'b0, done}, 32'd0);
        chk("post_ready", {31'b0, in_ready}, 32'd1);
        chk("post_flags", {29'b0, flag_c, flag_z, flag_n}, 32'd0);
        check_reg("post_r3", 3, 32'd0);
        run_instr(6'h01, 2, 0, 0, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
